// File: rtl/nmi_arbiter_if.sv
// CPU bus as seen by the NMI arbiter: registered address/data plus Z80 strobes.
interface nmi_arbiter_if;
    logic [15:0] a_reg;
    logic [7:0]  d_reg;
    logic        m1;
    logic        memreq;
    logic        ioreq;
    logic        rd;
    logic        wr;

    modport master (output a_reg, d_reg, m1, memreq, ioreq, rd, wr);
    modport slave  (input  a_reg, d_reg, m1, memreq, ioreq, rd, wr);
endinterface

// File: rtl/nmi_arbiter.sv
// NMI arbiter: latches per-source request edges, grants the lowest pending index at a frame
// boundary, holds n_nmi low until the CPU fetches 0x0066 (or a frame timeout expires) and
// exposes a cause/status register on an I/O port while the magic ROM is mapped.
module nmi_arbiter #(
    parameter int unsigned NSRC        = 4,
    parameter int unsigned TIMEOUT_FRM = 4,
    parameter logic [15:0] STATUS_PORT = 16'h0cff
) (
    input  logic            clk28,
    input  logic            rst_n,
    nmi_arbiter_if.slave    bus,
    input  logic            n_int,
    input  logic            n_int_next,
    input  logic [NSRC-1:0] req,
    input  logic [NSRC-1:0] req_mask,
    input  logic            magic_map,
    output logic            n_nmi,
    output logic            nmi_busy,
    output logic [1:0]      cause,
    output logic [7:0]      d_out,
    output logic            d_out_active
);

    localparam int unsigned CntW = $clog2(TIMEOUT_FRM) + 1;

    typedef enum logic [1:0] {StIdle, StAssert, StService} state_e;

    state_e            state_q, state_d;
    logic [NSRC-1:0]   pending_q, pending_d;
    logic [NSRC-1:0]   req_q;
    logic              magic_q;
    logic [1:0]        cause_q, cause_d;
    logic              timeout_q, timeout_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              d_out_active_q;

    logic              frame;
    logic              ack;
    logic              cs;
    logic              magic_fall;
    logic [NSRC-1:0]   rise;
    logic [NSRC-1:0]   wr_clr;
    logic [NSRC-1:0]   grant_oh;
    logic [1:0]        grant_idx;
    logic [3:0]        pend4;
    logic              unused_d_reg;

    assign frame        = n_int & ~n_int_next;
    assign ack          = bus.m1 & bus.memreq & (bus.a_reg == 16'h0066);
    assign cs           = magic_map & bus.ioreq & (bus.a_reg == STATUS_PORT);
    assign magic_fall   = magic_q & ~magic_map;
    assign rise         = req & ~req_q & ~req_mask;
    assign wr_clr       = bus.d_reg[4 +: NSRC];
    // Low data bits (and any beyond NSRC) have no write effect.
    assign unused_d_reg = ^bus.d_reg;

    // Lowest set pending index wins; scan from the top so the lowest overrides.
    always_comb begin
        grant_oh  = '0;
        grant_idx = '0;
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (pending_q[i]) begin
                grant_oh    = '0;
                grant_oh[i] = 1'b1;
                grant_idx   = 2'(i);
            end
        end
    end

    // Next-state, pending and status updates; request-edge set overrides any clear.
    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        cause_d   = cause_q;
        timeout_d = timeout_q;
        cnt_d     = cnt_q;

        if (cs && bus.wr) begin
            pending_d = pending_d & ~wr_clr;
            if (bus.d_reg[3]) begin
                timeout_d = 1'b0;
            end
        end

        unique case (state_q)
            StIdle: begin
                if ((pending_q != '0) && frame) begin
                    state_d   = StAssert;
                    cause_d   = grant_idx;
                    pending_d = pending_d & ~grant_oh;
                    cnt_d     = '0;
                end
            end
            StAssert: begin
                if (ack) begin
                    state_d = StService;
                end else if (frame) begin
                    if (cnt_q == CntW'(TIMEOUT_FRM - 1)) begin
                        state_d   = StIdle;
                        timeout_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            StService: begin
                // Leaving service never grants in the same cycle; IDLE re-evaluates later.
                if (magic_fall) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        pending_d = pending_d | rise;
    end

    // State and edge-detect registers.
    always_ff @(posedge clk28 or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= StIdle;
            pending_q      <= '0;
            req_q          <= '0;
            magic_q        <= 1'b0;
            cause_q        <= '0;
            timeout_q      <= 1'b0;
            cnt_q          <= '0;
            d_out_active_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            pending_q      <= pending_d;
            req_q          <= req;
            magic_q        <= magic_map;
            cause_q        <= cause_d;
            timeout_q      <= timeout_d;
            cnt_q          <= cnt_d;
            d_out_active_q <= cs & bus.rd;
        end
    end

    // Status register image, pending zero-extended to four bits.
    always_comb begin
        pend4             = '0;
        pend4[NSRC-1:0]   = pending_q;
    end

    assign n_nmi        = (state_q != StAssert);
    assign nmi_busy     = (state_q != StIdle);
    assign cause        = cause_q;
    assign d_out        = {pend4, timeout_q, nmi_busy, cause_q};
    assign d_out_active = d_out_active_q;

endmodule

// File: tb/tb_nmi_arbiter.sv
// Self-checking bench for nmi_arbiter: directed scenarios plus randomized traffic
// compared cycle by cycle against a behavioural model.
module tb_nmi_arbiter;

    logic       clk28 = 1'b0;
    logic       rst_n = 1'b0;
    logic       n_int = 1'b1;
    logic       n_int_next = 1'b1;
    logic [3:0] req = '0;
    logic [3:0] req_mask = '0;
    logic       magic_map = 1'b0;
    logic       n_nmi;
    logic       nmi_busy;
    logic [1:0] cause;
    logic [7:0] d_out;
    logic       d_out_active;

    int total = 0;
    int bad = 0;

    nmi_arbiter_if bus ();

    nmi_arbiter #(
        .NSRC        (4),
        .TIMEOUT_FRM (4),
        .STATUS_PORT (16'h0cff)
    ) dut (
        .clk28        (clk28),
        .rst_n        (rst_n),
        .bus          (bus),
        .n_int        (n_int),
        .n_int_next   (n_int_next),
        .req          (req),
        .req_mask     (req_mask),
        .magic_map    (magic_map),
        .n_nmi        (n_nmi),
        .nmi_busy     (nmi_busy),
        .cause        (cause),
        .d_out        (d_out),
        .d_out_active (d_out_active)
    );

    always #5 clk28 = ~clk28;

    // Behavioural model: phase 0 = quiet, 1 = NMI line held, 2 = handler running.
    int         m_phase;
    logic [3:0] m_pend;
    logic       m_to;
    logic [1:0] m_cause;
    int         m_bounds;
    logic [3:0] m_req_prev;
    logic       m_magic_prev;
    logic       m_act;
    logic       m_frame;
    logic       m_cs;
    logic       m_fetch;
    logic [3:0] m_np;
    logic [3:0] m_low;

    always @(posedge clk28 or negedge rst_n) begin
        if (!rst_n) begin
            m_phase = 0; m_pend = '0; m_to = 1'b0; m_cause = '0; m_bounds = 0;
            m_req_prev = '0; m_magic_prev = 1'b0; m_act = 1'b0;
        end else begin
            m_frame = n_int && !n_int_next;
            m_cs    = magic_map && bus.ioreq && (bus.a_reg == 16'h0cff);
            m_fetch = bus.m1 && bus.memreq && (bus.a_reg == 16'h0066);
            m_np    = m_pend;
            if (m_cs && bus.wr) begin
                m_np = m_np & ~bus.d_reg[7:4];
                if (bus.d_reg[3]) m_to = 1'b0;
            end
            if (m_phase == 0) begin
                if (m_pend != 0 && m_frame) begin
                    m_low    = m_pend & (~m_pend + 4'd1);
                    m_cause  = 2'($clog2(m_low));
                    m_np     = m_np & ~m_low;
                    m_phase  = 1;
                    m_bounds = 0;
                end
            end else if (m_phase == 1) begin
                if (m_fetch) begin
                    m_phase = 2;
                end else if (m_frame) begin
                    m_bounds = m_bounds + 1;
                    if (m_bounds == 4) begin
                        m_phase = 0;
                        m_to    = 1'b1;
                    end
                end
            end else begin
                if (m_magic_prev && !magic_map) m_phase = 0;
            end
            m_pend       = m_np | (req & ~m_req_prev & ~req_mask);
            m_act        = m_cs && bus.rd;
            m_req_prev   = req;
            m_magic_prev = magic_map;
        end
    end

    task automatic tick();
        @(posedge clk28);
        #1;
    endtask

    task automatic bus_idle();
        bus.a_reg = 16'h0000; bus.d_reg = 8'h00;
        bus.m1 = 1'b0; bus.memreq = 1'b0; bus.ioreq = 1'b0; bus.rd = 1'b0; bus.wr = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus_idle();
        n_int = 1'b1; n_int_next = 1'b1; req = '0; req_mask = '0; magic_map = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic frame();
        n_int_next = 1'b0;
        tick();
        n_int_next = 1'b1;
    endtask

    task automatic pulse_req(input int i);
        req[i] = 1'b1;
        tick();
        req[i] = 1'b0;
        tick();
    endtask

    task automatic fetch_0066();
        bus.a_reg = 16'h0066; bus.m1 = 1'b1; bus.memreq = 1'b1; bus.rd = 1'b1;
        tick();
        bus_idle();
    endtask

    task automatic read_status(output logic [7:0] data, output logic act);
        bus.a_reg = 16'h0cff; bus.ioreq = 1'b1; bus.rd = 1'b1;
        #1 data = d_out;
        tick();
        act = d_out_active;
        bus_idle();
    endtask

    task automatic write_status(input logic [7:0] v);
        bus.a_reg = 16'h0cff; bus.ioreq = 1'b1; bus.wr = 1'b1; bus.d_reg = v;
        tick();
        bus_idle();
    endtask

    task automatic test_reset();
        do_reset();
        total++;
        if ({n_nmi, nmi_busy, cause, d_out, d_out_active} !== {1'b1, 1'b0, 2'b00, 8'h00, 1'b0}) begin
            bad++;
            $display("FAIL reset_state got n_nmi=%b busy=%b cause=%0d d_out=%h act=%b exp 1 0 0 00 0",
                     n_nmi, nmi_busy, cause, d_out, d_out_active);
        end
    endtask

    task automatic test_single_grant();
        logic [7:0] st;
        logic act;
        do_reset();
        pulse_req(1);
        tick(); tick();
        total++;
        if (n_nmi !== 1'b1) begin bad++; $display("FAIL t1_pre_frame n_nmi got=%b exp=1", n_nmi); end
        frame();
        total++;
        if (n_nmi !== 1'b0) begin bad++; $display("FAIL t1_assert n_nmi got=%b exp=0", n_nmi); end
        total++;
        if (cause !== 2'd1) begin bad++; $display("FAIL t1_cause got=%0d exp=1", cause); end
        magic_map = 1'b1;
        fetch_0066();
        total++;
        if (n_nmi !== 1'b1) begin bad++; $display("FAIL t1_ack n_nmi got=%b exp=1", n_nmi); end
        read_status(st, act);
        total++;
        if (st !== 8'h05) begin bad++; $display("FAIL t1_status got=%h exp=05", st); end
        total++;
        if (act !== 1'b1) begin bad++; $display("FAIL t1_active got=%b exp=1", act); end
        magic_map = 1'b0;
        tick();
        total++;
        if (nmi_busy !== 1'b0) begin bad++; $display("FAIL t1_release busy got=%b exp=0", nmi_busy); end
    endtask

    task automatic test_priority();
        do_reset();
        req = 4'b0101;
        tick();
        req = 4'b0000;
        tick();
        frame();
        total++;
        if (cause !== 2'd0) begin bad++; $display("FAIL t2_first_cause got=%0d exp=0", cause); end
        total++;
        if (d_out[7:4] !== 4'b0100) begin bad++; $display("FAIL t2_pending got=%b exp=0100", d_out[7:4]); end
        magic_map = 1'b1;
        fetch_0066();
        magic_map = 1'b0;
        tick();
        total++;
        if (n_nmi !== 1'b1) begin bad++; $display("FAIL t2_gap n_nmi got=%b exp=1", n_nmi); end
        frame();
        total++;
        if ({n_nmi, cause} !== {1'b0, 2'd2}) begin
            bad++; $display("FAIL t2_second got n_nmi=%b cause=%0d exp 0 2", n_nmi, cause);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        pulse_req(0);
        frame();
        magic_map = 1'b1;
        fetch_0066();
        pulse_req(3);
        frame();
        total++;
        if (n_nmi !== 1'b1) begin bad++; $display("FAIL t3_in_service n_nmi got=%b exp=1", n_nmi); end
        total++;
        if (d_out[7:4] !== 4'b1000) begin bad++; $display("FAIL t3_pending got=%b exp=1000", d_out[7:4]); end
        // Leave service on the same cycle as a boundary: must not grant yet.
        magic_map = 1'b0;
        frame();
        total++;
        if (n_nmi !== 1'b1) begin bad++; $display("FAIL t3_exit_same_cycle n_nmi got=%b exp=1", n_nmi); end
        frame();
        total++;
        if ({n_nmi, cause} !== {1'b0, 2'd3}) begin
            bad++; $display("FAIL t3_later_grant got n_nmi=%b cause=%0d exp 0 3", n_nmi, cause);
        end
    endtask

    task automatic test_timeout();
        logic [7:0] st;
        logic act;
        do_reset();
        pulse_req(1);
        frame();
        for (int k = 0; k < 3; k++) begin
            frame();
            total++;
            if (n_nmi !== 1'b0) begin bad++; $display("FAIL t4_held_%0d n_nmi got=%b exp=0", k, n_nmi); end
        end
        frame();
        total++;
        if (n_nmi !== 1'b1) begin bad++; $display("FAIL t4_timeout n_nmi got=%b exp=1", n_nmi); end
        magic_map = 1'b1;
        read_status(st, act);
        total++;
        if (st !== 8'h09) begin bad++; $display("FAIL t4_status got=%h exp=09", st); end
        write_status(8'h08);
        read_status(st, act);
        total++;
        if (st !== 8'h01) begin bad++; $display("FAIL t4_cleared got=%h exp=01", st); end
        magic_map = 1'b0;
        tick();
    endtask

    task automatic test_mask_and_clear();
        do_reset();
        req_mask = 4'b0001;
        pulse_req(0);
        total++;
        if (d_out[7:4] !== 4'b0000) begin bad++; $display("FAIL t5_masked got=%b exp=0000", d_out[7:4]); end
        frame();
        total++;
        if (n_nmi !== 1'b1) begin bad++; $display("FAIL t5_masked_nmi got=%b exp=1", n_nmi); end
        req_mask = 4'b0000;
        pulse_req(1);
        pulse_req(2);
        total++;
        if (d_out[7:4] !== 4'b0110) begin bad++; $display("FAIL t5_pending got=%b exp=0110", d_out[7:4]); end
        magic_map = 1'b1;
        write_status(8'hF0);
        total++;
        if (d_out !== 8'h00) begin bad++; $display("FAIL t5_write_clear got=%h exp=00", d_out); end
        magic_map = 1'b0;
        tick();
    endtask

    task automatic test_async_reset();
        logic [7:0] st;
        logic act;
        do_reset();
        pulse_req(2);
        frame();
        total++;
        if (n_nmi !== 1'b0) begin bad++; $display("FAIL t6_assert got=%b exp=0", n_nmi); end
        rst_n = 1'b0;
        #1;
        total++;
        if ({n_nmi, nmi_busy, d_out} !== {1'b1, 1'b0, 8'h00}) begin
            bad++; $display("FAIL t6_async got n_nmi=%b busy=%b d_out=%h exp 1 0 00", n_nmi, nmi_busy, d_out);
        end
        #2 rst_n = 1'b1;
        tick();
        magic_map = 1'b0;
        read_status(st, act);
        total++;
        if (act !== 1'b0) begin bad++; $display("FAIL t6_unmapped_read act got=%b exp=0", act); end
    endtask

    task automatic test_random();
        int op;
        do_reset();
        for (int c = 0; c < 2000; c++) begin
            bus_idle();
            for (int b = 0; b < 4; b++) begin
                if ($urandom_range(0, 5) == 0) req[b] = ~req[b];
            end
            if ($urandom_range(0, 40) == 0) req_mask = 4'($urandom_range(0, 15));
            n_int      = ($urandom_range(0, 7) != 0);
            n_int_next = ($urandom_range(0, 5) != 0);
            if ($urandom_range(0, 9) == 0) magic_map = ~magic_map;
            op = $urandom_range(0, 7);
            case (op)
                3: begin bus.a_reg = 16'h0066; bus.m1 = 1'b1; bus.memreq = 1'b1; bus.rd = 1'b1; end
                4: begin bus.a_reg = 16'($urandom); bus.m1 = 1'b1; bus.memreq = 1'b1; end
                5: begin bus.a_reg = 16'h0cff; bus.ioreq = 1'b1; bus.rd = 1'b1; end
                6: begin bus.a_reg = 16'h0cff; bus.ioreq = 1'b1; bus.wr = 1'b1;
                         bus.d_reg = 8'($urandom); end
                7: begin bus.a_reg = 16'h0cfe; bus.ioreq = 1'b1; bus.rd = 1'b1; end
                default: ;
            endcase
            tick();
            total++;
            if (d_out !== {m_pend, m_to, (m_phase != 0), m_cause}) begin
                bad++;
                $display("FAIL rnd_status cycle=%0d got=%h exp=%h", c, d_out,
                         {m_pend, m_to, (m_phase != 0), m_cause});
            end
            total++;
            if (n_nmi !== (m_phase != 1)) begin
                bad++; $display("FAIL rnd_n_nmi cycle=%0d got=%b exp=%b", c, n_nmi, (m_phase != 1));
            end
            total++;
            if (d_out_active !== m_act) begin
                bad++; $display("FAIL rnd_active cycle=%0d got=%b exp=%b", c, d_out_active, m_act);
            end
        end
        bus_idle();
    endtask

    initial begin
        bus_idle();
        test_reset();
        test_single_grant();
        test_priority();
        test_back_to_back();
        test_timeout();
        test_mask_and_clear();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
